// File: rtl/debug_run_controller_pkg.sv
// Shared state encodings and halt cause codes for the debug run controller.
package debug_run_controller_pkg;

  typedef enum logic [1:0] {
    s_RUN      = 2'd0,
    s_HALTING  = 2'd1,
    s_HALTED   = 2'd2,
    s_STEPPING = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_HOST       = 2'd1,
    CAUSE_BREAKPOINT = 2'd2,
    CAUSE_STEP       = 2'd3
  } cause_e;

  // The core is held in HALTING (draining) and HALTED; it runs otherwise.
  function automatic logic is_stalled(input state_e s);
    return (s == s_HALTING) || (s == s_HALTED);
  endfunction

endpackage

// File: rtl/debug_run_controller_breakpoint_unit.sv
// PC breakpoint slots with parallel compare and lowest-index priority encode.
module breakpoint_unit #(
  parameter int NUM_BREAKPOINTS = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Bp_Write,
  input  logic [2:0]  i_Bp_Index,
  input  logic [31:0] i_Bp_Addr,
  input  logic        i_Bp_Enable,
  input  logic [31:0] i_PC,
  output logic        o_Match,
  output logic [2:0]  o_Index
);

  logic [NUM_BREAKPOINTS-1:0] hit;

  // Slot indices with no generated slot never match, so out-of-range writes drop out.
  for (genvar gi = 0; gi < NUM_BREAKPOINTS; gi++) begin : g_slot
    logic [31:0] addr_reg;
    logic        enable_reg;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
        addr_reg   <= '0;
        enable_reg <= 1'b0;
      end else if (i_Bp_Write && (i_Bp_Index == 3'(gi))) begin
        addr_reg   <= i_Bp_Addr;
        enable_reg <= i_Bp_Enable;
      end
    end

    assign hit[gi] = enable_reg && (addr_reg == i_PC);
  end

  always_comb begin
    o_Match = |hit;
    o_Index = 3'd0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (hit[i]) o_Index = 3'(i);
    end
  end

endmodule

// File: rtl/debug_run_controller.sv
// Debug run control: halt/resume, N-instruction stepping and PC breakpoints,
// with a pipeline-drain handshake before debug access is granted.
module debug_run_controller
  import debug_run_controller_pkg::*;
#(
  parameter int NUM_BREAKPOINTS = 4,
  parameter int STEP_WIDTH      = 16,
  parameter int HALT_ON_RESET   = 0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Halt_Req,
  input  logic                  i_Resume_Req,
  input  logic                  i_Step_Req,
  input  logic [STEP_WIDTH-1:0] i_Step_Count,
  input  logic                  i_Bp_Write,
  input  logic [2:0]            i_Bp_Index,
  input  logic [31:0]           i_Bp_Addr,
  input  logic                  i_Bp_Enable,
  input  logic [31:0]           i_PC,
  input  logic                  i_Instr_Retire,
  input  logic                  i_Pipeline_Flushed,
  output logic                  o_Stall_Cpu,
  output logic                  o_Halted,
  output logic                  o_Halt_Event,
  output logic [1:0]            o_Halt_Cause,
  output logic [2:0]            o_Bp_Hit_Index
);

  localparam state_e RESET_STATE = (HALT_ON_RESET != 0) ? s_HALTING : s_RUN;
  localparam cause_e RESET_CAUSE = (HALT_ON_RESET != 0) ? CAUSE_HOST : CAUSE_NONE;

  state_e                state_reg, state_next;
  cause_e                cause_reg, cause_next;
  logic [2:0]            hit_index_reg, hit_index_next;
  logic [STEP_WIDTH-1:0] step_reg, step_next;
  logic                  suppress_reg, suppress_next;
  logic                  event_reg, event_next;
  logic                  stall_reg;
  logic                  bp_match;
  logic [2:0]            bp_index;
  logic                  bp_hit;

  breakpoint_unit #(
    .NUM_BREAKPOINTS(NUM_BREAKPOINTS)
  ) u_breakpoint_unit (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Bp_Write (i_Bp_Write),
    .i_Bp_Index (i_Bp_Index),
    .i_Bp_Addr  (i_Bp_Addr),
    .i_Bp_Enable(i_Bp_Enable),
    .i_PC       (i_PC),
    .o_Match    (bp_match),
    .o_Index    (bp_index)
  );

  // Suppression keeps us from re-halting on the breakpoint we just resumed from.
  assign bp_hit = bp_match && !suppress_reg;

  always_comb begin
    state_next     = state_reg;
    cause_next     = cause_reg;
    hit_index_next = hit_index_reg;
    step_next      = step_reg;
    suppress_next  = suppress_reg;
    event_next     = 1'b0;

    case (state_reg)
      s_RUN: begin
        if (i_Instr_Retire) suppress_next = 1'b0;
        if (i_Halt_Req) begin
          state_next = s_HALTING;
          cause_next = CAUSE_HOST;
        end else if (bp_hit) begin
          state_next     = s_HALTING;
          cause_next     = CAUSE_BREAKPOINT;
          hit_index_next = bp_index;
        end
      end

      s_STEPPING: begin
        if (i_Instr_Retire) begin
          suppress_next = 1'b0;
          if (step_reg != '0) step_next = step_reg - STEP_WIDTH'(1);
        end
        if (i_Halt_Req) begin
          state_next = s_HALTING;
          cause_next = CAUSE_HOST;
        end else if (bp_hit) begin
          state_next     = s_HALTING;
          cause_next     = CAUSE_BREAKPOINT;
          hit_index_next = bp_index;
        end else if (i_Instr_Retire && (step_reg == STEP_WIDTH'(1))) begin
          state_next = s_HALTING;
          cause_next = CAUSE_STEP;
        end
      end

      // Retirements seen here are the pipeline draining and are not counted.
      s_HALTING: begin
        if (i_Pipeline_Flushed) begin
          state_next = s_HALTED;
          event_next = 1'b1;
        end
      end

      s_HALTED: begin
        if (i_Step_Req) begin
          state_next    = s_STEPPING;
          step_next     = (i_Step_Count == '0) ? STEP_WIDTH'(1) : i_Step_Count;
          suppress_next = 1'b1;
        end else if (i_Resume_Req) begin
          state_next    = s_RUN;
          suppress_next = 1'b1;
        end
      end

      default: state_next = s_RUN;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg     <= RESET_STATE;
      cause_reg     <= RESET_CAUSE;
      hit_index_reg <= 3'd0;
      step_reg      <= '0;
      suppress_reg  <= 1'b0;
      event_reg     <= 1'b0;
      stall_reg     <= (HALT_ON_RESET != 0);
    end else begin
      state_reg     <= state_next;
      cause_reg     <= cause_next;
      hit_index_reg <= hit_index_next;
      step_reg      <= step_next;
      suppress_reg  <= suppress_next;
      event_reg     <= event_next;
      stall_reg     <= is_stalled(state_next);
    end
  end

  assign o_Stall_Cpu    = stall_reg;
  assign o_Halted       = (state_reg == s_HALTED);
  assign o_Halt_Event   = event_reg;
  assign o_Halt_Cause   = cause_reg;
  assign o_Bp_Hit_Index = hit_index_reg;

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed bench for debug_run_controller; expectations are queued when stimulus
// is driven and popped against the packed DUT outputs after each clock edge.
module tb_debug_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, resume_req, step_req;
  logic [15:0] step_count;
  logic        bp_write;
  logic [2:0]  bp_index;
  logic [31:0] bp_addr;
  logic        bp_enable;
  logic [31:0] pc;
  logic        retire, flushed;

  logic       a_stall, a_halted, a_event;
  logic [1:0] a_cause;
  logic [2:0] a_idx;
  logic       h_stall, h_halted, h_event;
  logic [1:0] h_cause;
  logic [2:0] h_idx;

  always #5 clk = ~clk;

  debug_run_controller #(.NUM_BREAKPOINTS(4), .STEP_WIDTH(16), .HALT_ON_RESET(0)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Halt_Req(halt_req), .i_Resume_Req(resume_req),
    .i_Step_Req(step_req), .i_Step_Count(step_count), .i_Bp_Write(bp_write),
    .i_Bp_Index(bp_index), .i_Bp_Addr(bp_addr), .i_Bp_Enable(bp_enable), .i_PC(pc),
    .i_Instr_Retire(retire), .i_Pipeline_Flushed(flushed), .o_Stall_Cpu(a_stall),
    .o_Halted(a_halted), .o_Halt_Event(a_event), .o_Halt_Cause(a_cause),
    .o_Bp_Hit_Index(a_idx)
  );

  debug_run_controller #(.NUM_BREAKPOINTS(4), .STEP_WIDTH(16), .HALT_ON_RESET(1)) dut_h (
    .i_Clock(clk), .i_Reset(rst), .i_Halt_Req(halt_req), .i_Resume_Req(resume_req),
    .i_Step_Req(step_req), .i_Step_Count(step_count), .i_Bp_Write(bp_write),
    .i_Bp_Index(bp_index), .i_Bp_Addr(bp_addr), .i_Bp_Enable(bp_enable), .i_PC(pc),
    .i_Instr_Retire(retire), .i_Pipeline_Flushed(flushed), .o_Stall_Cpu(h_stall),
    .o_Halted(h_halted), .o_Halt_Event(h_event), .o_Halt_Cause(h_cause),
    .o_Bp_Hit_Index(h_idx)
  );

  wire [7:0] obs_a = {a_stall, a_halted, a_event, a_cause, a_idx};
  wire [7:0] obs_h = {h_stall, h_halted, h_event, h_cause, h_idx};

  typedef struct {
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [7:0] pack(input logic s, input logic h, input logic e,
                                      input logic [1:0] c, input logic [2:0] i);
    return {s, h, e, c, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] e, input logic [7:0] m);
    sb_t t;
    t.tag  = tag;
    t.exp  = e;
    t.mask = m;
    sb_q.push_back(t);
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t t;
    vectors++;
    assert (sb_q.size() != 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %02h required a queued entry", obs);
      return;
    end
    t = sb_q.pop_front();
    assert ((obs & t.mask) === (t.exp & t.mask)) else begin
      miscompares++;
      $error("FAIL %s: observed %02h required %02h (mask %02h)",
             t.tag, obs & t.mask, t.exp & t.mask, t.mask);
    end
  endtask

  // One cycle of i_Pipeline_Flushed while HALTING: expect the event pulse.
  task automatic drain(input string tag, input logic [1:0] c, input logic [2:0] i,
                       input logic [7:0] m);
    flushed = 1'b1;
    push(tag, pack(1'b1, 1'b1, 1'b1, c, i), m);
    tick();
    flushed = 1'b0;
    check(obs_a);
  endtask

  task automatic bp_wr(input logic [2:0] idx, input logic [31:0] addr);
    bp_write = 1'b1; bp_index = idx; bp_addr = addr; bp_enable = 1'b1;
    tick();
    bp_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    halt_req = 0; resume_req = 0; step_req = 0; step_count = '0;
    bp_write = 0; bp_index = '0; bp_addr = '0; bp_enable = 0;
    pc = 32'h0; retire = 0; flushed = 0;
    repeat (2) tick();
    push("reset_state", pack(0, 0, 0, 2'd0, 3'd0), 8'hFF);
    push("reset_state_hor", pack(1, 0, 0, 2'd1, 3'd0), 8'hFF);
    check(obs_a);
    check(obs_h);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Host halt with a slow drain.
    halt_req = 1'b1;
    push("host_halt_stall", pack(1, 0, 0, 2'd0, 3'd0), 8'hE0);
    tick();
    halt_req = 1'b0;
    check(obs_a);
    repeat (5) begin
      push("halting_hold", pack(1, 0, 0, 2'd0, 3'd0), 8'hE0);
      tick();
      check(obs_a);
    end
    drain("host_halted", 2'd1, 3'd0, 8'hF8);
    push("event_one_cycle", pack(1, 1, 0, 2'd1, 3'd0), 8'hF8);
    tick();
    check(obs_a);

    // Breakpoint on slot 2 and suppression on resume.
    bp_wr(3'd2, 32'h0000_0040);
    pc = 32'h20;
    resume_req = 1'b1;
    push("resume_to_run", pack(0, 0, 0, 2'd1, 3'd0), 8'hF8);
    tick();
    resume_req = 1'b0;
    check(obs_a);
    retire = 1'b1;
    push("retire_in_run", pack(0, 0, 0, 2'd1, 3'd0), 8'hF8);
    tick();
    retire = 1'b0;
    check(obs_a);
    pc = 32'h40;
    push("bp_halt", pack(1, 0, 0, 2'd2, 3'd2), 8'hFF);
    tick();
    check(obs_a);
    drain("bp_halted", 2'd2, 3'd2, 8'hFF);
    resume_req = 1'b1;
    push("resume_on_bp", pack(0, 0, 0, 2'd2, 3'd2), 8'hFF);
    tick();
    resume_req = 1'b0;
    check(obs_a);
    repeat (2) begin
      push("bp_suppressed", pack(0, 0, 0, 2'd2, 3'd2), 8'hFF);
      tick();
      check(obs_a);
    end
    retire = 1'b1;
    push("retire_clears_suppress", pack(0, 0, 0, 2'd2, 3'd2), 8'hFF);
    tick();
    retire = 1'b0;
    check(obs_a);
    push("rehalt_after_retire", pack(1, 0, 0, 2'd2, 3'd2), 8'hFF);
    tick();
    check(obs_a);
    drain("rehalted", 2'd2, 3'd2, 8'hFF);

    // Step three instructions, then a zero-count step.
    pc = 32'h44;
    step_req = 1'b1; step_count = 16'd3;
    push("step3_start", pack(0, 0, 0, 2'd2, 3'd2), 8'hFF);
    tick();
    step_req = 1'b0;
    check(obs_a);
    for (int i = 0; i < 2; i++) begin
      retire = 1'b1;
      push("step3_retire", pack(0, 0, 0, 2'd2, 3'd2), 8'hFF);
      tick();
      retire = 1'b0;
      check(obs_a);
    end
    retire = 1'b1;
    push("step3_done", pack(1, 0, 0, 2'd3, 3'd2), 8'hFF);
    tick();
    retire = 1'b0;
    check(obs_a);
    drain("step3_halted", 2'd3, 3'd2, 8'hFF);
    step_req = 1'b1; step_count = 16'd0;
    push("step0_start", pack(0, 0, 0, 2'd3, 3'd2), 8'hFF);
    tick();
    step_req = 1'b0;
    check(obs_a);
    retire = 1'b1;
    push("step0_as_one", pack(1, 0, 0, 2'd3, 3'd2), 8'hFF);
    tick();
    retire = 1'b0;
    check(obs_a);
    drain("step0_halted", 2'd3, 3'd2, 8'hFF);

    // Slots 1 and 3 on 0x80: host wins a tie, lowest slot reported otherwise.
    bp_wr(3'd1, 32'h80);
    bp_wr(3'd3, 32'h80);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    pc = 32'h80; halt_req = 1'b1;
    push("host_beats_bp", pack(1, 0, 0, 2'd1, 3'd0), 8'hF8);
    tick();
    halt_req = 1'b0;
    check(obs_a);
    drain("host_tie_halted", 2'd1, 3'd0, 8'hF8);
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    retire = 1'b1;
    push("bp_tie_suppressed", pack(0, 0, 0, 2'd1, 3'd0), 8'hF8);
    tick();
    retire = 1'b0;
    check(obs_a);
    push("bp_lowest_slot", pack(1, 0, 0, 2'd2, 3'd1), 8'hFF);
    tick();
    check(obs_a);
    drain("bp_lowest_halted", 2'd2, 3'd1, 8'hFF);

    // Resume and step together: step wins.
    pc = 32'h44;
    resume_req = 1'b1; step_req = 1'b1; step_count = 16'd2;
    push("step_beats_resume", pack(0, 0, 0, 2'd2, 3'd1), 8'hFF);
    tick();
    resume_req = 1'b0; step_req = 1'b0;
    check(obs_a);
    retire = 1'b1;
    tick();
    push("step_beats_resume_done", pack(1, 0, 0, 2'd3, 3'd1), 8'hFF);
    tick();
    retire = 1'b0;
    check(obs_a);
    drain("step2_halted", 2'd3, 3'd1, 8'hFF);

    // Resume in RUN is ignored; out-of-range slot writes are ignored.
    resume_req = 1'b1;
    tick();
    resume_req = 1'b0;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    resume_req = 1'b1;
    push("resume_in_run_ignored", pack(0, 0, 0, 2'd3, 3'd1), 8'hFF);
    tick();
    resume_req = 1'b0;
    check(obs_a);
    bp_wr(3'd5, 32'h44);
    push("slot5_ignored", pack(0, 0, 0, 2'd3, 3'd1), 8'hFF);
    tick();
    check(obs_a);

    // Reset in the middle of a 5-instruction step.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    drain("pre_reset_halted", 2'd1, 3'd1, 8'hFF);
    step_req = 1'b1; step_count = 16'd5;
    push("step5_start", pack(0, 0, 0, 2'd1, 3'd1), 8'hFF);
    tick();
    step_req = 1'b0;
    check(obs_a);
    #2;
    rst = 1'b1;
    #1;
    push("reset_mid_step", pack(0, 0, 0, 2'd0, 3'd0), 8'hFF);
    push("reset_mid_step_hor", pack(1, 0, 0, 2'd1, 3'd0), 8'hFF);
    check(obs_a);
    check(obs_h);
    @(negedge clk);
    rst = 1'b0;
    pc = 32'h80;
    tick();
    push("slots_cleared", pack(0, 0, 0, 2'd0, 3'd0), 8'hFF);
    tick();
    check(obs_a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Sequences CPU execution for the debug path: halt/resume, N-instruction single-step, and PC breakpoints. Drives the core stall line and waits for the pipeline-drain handshake before granting debug access. Sits between the UART debug command decoder and the CPU core, and is the sole source of the core halt signal. `o_Halted` tells the decoder when register and PC access is safe.

## Interface
- NUM_BREAKPOINTS, 4: number of PC breakpoint slots (1-8).
- STEP_WIDTH, 16: width of the step counter.
- HALT_ON_RESET, 0: when 1, reset enters HALTING with cause HOST instead of RUN.

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  reset, asynchronous, active-high.
- i_Halt_Req  in  1  pulse: host halt.
- i_Resume_Req  in  1  pulse: resume free-running.
- i_Step_Req  in  1  pulse: execute i_Step_Count instructions, then halt.
- i_Step_Count  in  STEP_WIDTH  step count; 0 treated as 1.
- i_Bp_Write  in  1  pulse: write breakpoint slot.
- i_Bp_Index  in  3  slot index; index >= NUM_BREAKPOINTS ignored.
- i_Bp_Addr  in  32  breakpoint PC.
- i_Bp_Enable  in  1  slot enable written with address.
- i_PC  in  32  core fetch PC.
- i_Instr_Retire  in  1  one pulse per retired instruction.
- i_Pipeline_Flushed  in  1  core pipeline empty.
- o_Stall_Cpu  out  1  core halt; registered.
- o_Halted  out  1  high in HALTED only.
- o_Halt_Event  out  1  one-cycle pulse on HALTING->HALTED.
- o_Halt_Cause  out  2  cause of the last halt; held until the next halt.
- o_Bp_Hit_Index  out  3  slot of the last breakpoint hit.

## Operation
- States: RUN, HALTING, HALTED, STEPPING.
- Reset values: o_Stall_Cpu 0, o_Halted 0, o_Halt_Event 0, o_Halt_Cause NONE, o_Bp_Hit_Index 0, all slots disabled, step counter 0, suppress flag 0.
- With HALT_ON_RESET=1, reset enters HALTING, o_Stall_Cpu resets to 1, and o_Halt_Cause resets to HOST.
- RUN:
  - i_Halt_Req -> HALTING, cause HOST.
  - Enabled slot address == i_PC with suppress clear -> HALTING, cause BREAKPOINT. o_Bp_Hit_Index is the lowest matching index.
- HALTING: o_Stall_Cpu=1. i_Pipeline_Flushed high -> HALTED, pulse o_Halt_Event.
- HALTED: o_Stall_Cpu=1.
  - i_Resume_Req -> RUN.
  - i_Step_Req -> STEPPING; counter = max(i_Step_Count,1).
  - Both requests in the same cycle -> step wins.
  - Both transitions set the suppress flag.
- STEPPING:
  - o_Stall_Cpu=0. Each i_Instr_Retire decrements the counter.
  - Retire with counter==1 -> HALTING, cause STEP.
  - Breakpoints and i_Halt_Req are also active in STEPPING.
- Suppress flag: cleared on the first i_Instr_Retire after leaving HALTED. It prevents an immediate re-halt on the breakpoint just resumed from.
- Ignored requests:
  - Halt in HALTING or HALTED.
  - Resume or step in RUN, HALTING or STEPPING.
- Simultaneous halt sources in one cycle: cause priority HOST > BREAKPOINT > STEP.
- Retirements during HALTING: these are drain retirements. They are not counted and do not change state.
- Breakpoint writes are accepted in any state and take effect for comparisons on the next cycle.

## Timing
- Transitions are registered. o_Stall_Cpu rises on the clock edge that enters HALTING, one cycle after the halt-triggering input.
- HALTING lasts at least 1 cycle. i_Pipeline_Flushed is sampled only while in HALTING.
- o_Halted rises in the same cycle as the o_Halt_Event pulse.
- o_Stall_Cpu falls on the edge that leaves HALTED. o_Halted falls in the same cycle.
- Reset mid-operation: asynchronous return to reset values. Breakpoints are cleared and any in-progress step is dropped.

## Structure
- Shared include debug_run_controller.vh:
  - State encodings s_RUN, s_HALTING, s_HALTED, s_STEPPING.
  - Cause codes CAUSE_NONE=0, CAUSE_HOST=1, CAUSE_BREAKPOINT=2, CAUSE_STEP=3.
- One sub-module, breakpoint_unit: slot registers, parallel PC compare, lowest-index priority encoder. Outputs are match and index.

## Test plan
- Reset then i_Halt_Req: o_Stall_Cpu=1 next cycle. Hold i_Pipeline_Flushed low 5 cycles then raise -> one o_Halt_Event, o_Halted=1, cause=1.
- Slot 2 = 0x0000_0040 enabled, i_PC reaches 0x40 -> halt, cause=2, o_Bp_Hit_Index=2. Resume: i_PC remains 0x40 -> no re-halt until after first retire.
- Halted, i_Step_Count=3: exactly 3 retire pulses with stall low, then stall=1, cause=3. i_Step_Count=0 -> behaves as 1.
- Slots 1 and 3 both 0x80 and i_Halt_Req on the same cycle -> cause=1 (host).
- i_Resume_Req and i_Step_Req together while HALTED -> STEPPING. i_Resume_Req in RUN -> no change.
- i_Reset asserted during STEPPING with counter 5 -> RUN, o_Stall_Cpu=0, slots disabled. With HALT_ON_RESET=1 -> o_Stall_Cpu=1 immediately.
